// File: rtl/pe_gnt_dispatch.sv
// rtl/pe_gnt_dispatch.sv - pending-request tracker and one-hot grant dispatcher for a wide priority encoder
module pe_gnt_dispatch #(
    parameter int W  = 256,
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_vld,
    input  logic [W-1:0]  set_vec,
    output logic [W-1:0]  Req,
    input  logic [W-1:0]  Gnt,
    input  logic          valid,
    output logic          out_vld,
    output logic [IW-1:0] out_idx,
    input  logic          out_rdy,
    output logic [IW-1:0] ptr,
    output logic          busy,
    output logic          err
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_pend;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_ptr;
    logic          r_err;

    logic [IW-1:0] w_enc;
    logic [W-1:0]  w_gnt_m1;
    logic          w_onehot;
    logic          w_gnt_ok;
    logic          w_any_pend;
    logic          w_err_now;
    logic          w_cap;
    logic [W-1:0]  w_clr;
    logic [W-1:0]  w_set;
    logic [W-1:0]  w_pend_nxt;

    // Binary encode of the grant; only meaningful when the grant is one-hot.
    always_comb begin
        w_enc = '0;
        for (int i = 0; i < W; i++) begin
            if (Gnt[i]) begin
                w_enc = w_enc | IW'(i);
            end
        end
    end

    // Grant sanity, protocol-error detection and the capture decision.
    always_comb begin
        w_gnt_m1   = Gnt - W'(1);
        w_onehot   = (Gnt != '0) && ((Gnt & w_gnt_m1) == '0);
        w_gnt_ok   = w_onehot && ((Gnt & ~r_pend) == '0);
        w_any_pend = |r_pend;
        w_err_now  = (valid && !w_gnt_ok) || (valid != w_any_pend);
        // An erroneous cycle never captures, even if the grant itself looks fine.
        w_cap      = valid && w_gnt_ok && !w_err_now &&
                     ((r_state == ST_EMPTY) || out_rdy);
    end

    // Next pending vector: a set in the same cycle as the grant re-arms the bit.
    always_comb begin
        w_clr      = w_cap ? Gnt : '0;
        w_set      = set_vld ? set_vec : '0;
        w_pend_nxt = (r_pend & ~w_clr) | w_set;
    end

    // Output-stage next state: capture keeps/enters HOLD, accept without capture drains.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_cap) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_cap) begin
                    w_state_nxt = ST_HOLD;
                end else if (out_rdy) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // State, pending vector, captured index, rotating pointer and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_pend  <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_err   <= r_err | w_err_now;
            if (w_cap) begin
                r_idx <= w_enc;
                // Natural IW-bit overflow gives the W-1 -> 0 wrap since W is 2**IW.
                r_ptr <= w_enc + IW'(1);
            end
        end
    end

    // Outputs come straight from registers; busy is a pure function of state.
    always_comb begin
        Req     = r_pend;
        out_vld = (r_state == ST_HOLD);
        out_idx = r_idx;
        ptr     = r_ptr;
        err     = r_err;
        busy    = (|r_pend) || (r_state == ST_HOLD);
    end

endmodule

// File: tb/tb_pe_gnt_dispatch.sv
// tb/tb_pe_gnt_dispatch.sv - directed self-checking bench for pe_gnt_dispatch
module tb_pe_gnt_dispatch;

    localparam int W  = 256;
    localparam int IW = 8;

    logic          clk;
    logic          rst;
    logic          set_vld;
    logic [W-1:0]  set_vec;
    logic [W-1:0]  Req;
    logic [W-1:0]  Gnt;
    logic          valid;
    logic          out_vld;
    logic [IW-1:0] out_idx;
    logic          out_rdy;
    logic [IW-1:0] ptr;
    logic          busy;
    logic          err;

    logic          force_en;
    logic [W-1:0]  force_gnt;
    logic          force_valid;

    int checks;
    int errors;

    pe_gnt_dispatch #(.W(W), .IW(IW)) dut (
        .clk     (clk),
        .rst     (rst),
        .set_vld (set_vld),
        .set_vec (set_vec),
        .Req     (Req),
        .Gnt     (Gnt),
        .valid   (valid),
        .out_vld (out_vld),
        .out_idx (out_idx),
        .out_rdy (out_rdy),
        .ptr     (ptr),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference simple encoder: lowest set bit wins, unless a test overrides it.
    always_comb begin
        if (force_en) begin
            Gnt   = force_gnt;
            valid = force_valid;
        end else begin
            Gnt   = Req & (~Req + W'(1));
            valid = |Req;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (Req !== '0)      begin errors++; $display("FAIL reset_req got %h exp 0", Req); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b exp 0", out_vld); end
        checks++; if (out_idx !== 8'd0) begin errors++; $display("FAIL reset_out_idx got %0d exp 0", out_idx); end
        checks++; if (ptr !== 8'd0)     begin errors++; $display("FAIL reset_ptr got %0d exp 0", ptr); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        out_rdy = 1'b1;
        set_vld = 1'b1;
        set_vec = W'(32'h0A);
        step();
        set_vld = 1'b0;
        set_vec = '0;
        checks++; if (Req !== W'(32'h0A)) begin errors++; $display("FAIL basic_req_n got %h exp a", Req); end
        checks++; if (out_vld !== 1'b0)   begin errors++; $display("FAIL basic_vld_n got %b exp 0", out_vld); end
        step();
        checks++; if (out_vld !== 1'b1)   begin errors++; $display("FAIL basic_vld1 got %b exp 1", out_vld); end
        checks++; if (out_idx !== 8'd1)   begin errors++; $display("FAIL basic_idx1 got %0d exp 1", out_idx); end
        checks++; if (Req !== W'(32'h08)) begin errors++; $display("FAIL basic_req1 got %h exp 8", Req); end
        checks++; if (ptr !== 8'd2)       begin errors++; $display("FAIL basic_ptr1 got %0d exp 2", ptr); end
        step();
        checks++; if (out_vld !== 1'b1)   begin errors++; $display("FAIL basic_vld3 got %b exp 1", out_vld); end
        checks++; if (out_idx !== 8'd3)   begin errors++; $display("FAIL basic_idx3 got %0d exp 3", out_idx); end
        checks++; if (Req !== '0)         begin errors++; $display("FAIL basic_req3 got %h exp 0", Req); end
        step();
        checks++; if (out_vld !== 1'b0)   begin errors++; $display("FAIL basic_drain_vld got %b exp 0", out_vld); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL basic_busy got %b exp 0", busy); end
        checks++; if (ptr !== 8'd4)       begin errors++; $display("FAIL basic_ptr_end got %0d exp 4", ptr); end
        checks++; if (out_idx !== 8'd3)   begin errors++; $display("FAIL basic_idx_hold got %0d exp 3", out_idx); end
    endtask

    task automatic test_backpressure();
        out_rdy = 1'b0;
        set_vld = 1'b1;
        set_vec = W'(32'h0A);
        step();
        set_vld = 1'b0;
        set_vec = '0;
        step();
        for (int c = 0; c < 5; c++) begin
            checks++; if (out_vld !== 1'b1)   begin errors++; $display("FAIL bp_vld[%0d] got %b exp 1", c, out_vld); end
            checks++; if (out_idx !== 8'd1)   begin errors++; $display("FAIL bp_idx[%0d] got %0d exp 1", c, out_idx); end
            checks++; if (Req !== W'(32'h08)) begin errors++; $display("FAIL bp_req[%0d] got %h exp 8", c, Req); end
            if (c < 4) step();
        end
        out_rdy = 1'b1;
        step();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL bp_rel_vld got %b exp 1", out_vld); end
        checks++; if (out_idx !== 8'd3) begin errors++; $display("FAIL bp_rel_idx got %0d exp 3", out_idx); end
        checks++; if (Req !== '0)       begin errors++; $display("FAIL bp_rel_req got %h exp 0", Req); end
        step();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_vld); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] top_bit;
        top_bit = '0;
        top_bit[W-1] = 1'b1;
        out_rdy = 1'b1;
        set_vld = 1'b1;
        set_vec = top_bit;
        step();
        set_vld = 1'b0;
        set_vec = '0;
        step();
        checks++; if (out_vld !== 1'b1)   begin errors++; $display("FAIL wrap_vld got %b exp 1", out_vld); end
        checks++; if (out_idx !== 8'd255) begin errors++; $display("FAIL wrap_idx got %0d exp 255", out_idx); end
        checks++; if (ptr !== 8'd0)       begin errors++; $display("FAIL wrap_ptr got %0d exp 0", ptr); end
        step();
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL wrap_busy got %b exp 0", busy); end
    endtask

    task automatic test_rearm();
        out_rdy = 1'b1;
        set_vld = 1'b1;
        set_vec = W'(32'h20);
        step();
        // Bit 5 is being captured this cycle; arm it again at the same time.
        step();
        set_vld = 1'b0;
        set_vec = '0;
        checks++; if (out_idx !== 8'd5)   begin errors++; $display("FAIL rearm_idx_a got %0d exp 5", out_idx); end
        checks++; if (Req !== W'(32'h20)) begin errors++; $display("FAIL rearm_req got %h exp 20", Req); end
        step();
        checks++; if (out_vld !== 1'b1)   begin errors++; $display("FAIL rearm_vld_b got %b exp 1", out_vld); end
        checks++; if (out_idx !== 8'd5)   begin errors++; $display("FAIL rearm_idx_b got %0d exp 5", out_idx); end
        checks++; if (Req !== '0)         begin errors++; $display("FAIL rearm_req_b got %h exp 0", Req); end
        checks++; if (ptr !== 8'd6)       begin errors++; $display("FAIL rearm_ptr got %0d exp 6", ptr); end
        step();
        checks++; if (out_vld !== 1'b0)   begin errors++; $display("FAIL rearm_drain got %b exp 0", out_vld); end
    endtask

    task automatic test_err();
        out_rdy     = 1'b1;
        force_en    = 1'b1;
        force_gnt   = W'(32'h3);
        force_valid = 1'b1;
        set_vld     = 1'b1;
        set_vec     = W'(32'h3);
        step();
        set_vld = 1'b0;
        set_vec = '0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (err !== 1'b1)      begin errors++; $display("FAIL err_hold[%0d] got %b exp 1", c, err); end
            checks++; if (out_vld !== 1'b0)  begin errors++; $display("FAIL err_nocap[%0d] got %b exp 0", c, out_vld); end
            checks++; if (Req !== W'(32'h3)) begin errors++; $display("FAIL err_req[%0d] got %h exp 3", c, Req); end
            checks++; if (ptr !== 8'd6)      begin errors++; $display("FAIL err_ptr[%0d] got %0d exp 6", c, ptr); end
        end
        force_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr got %b exp 0", err); end
        checks++; if (Req !== '0)   begin errors++; $display("FAIL err_rst_req got %h exp 0", Req); end
    endtask

    task automatic test_rst_in_hold();
        out_rdy = 1'b0;
        set_vld = 1'b1;
        set_vec = W'(32'hF0);
        step();
        set_vld = 1'b0;
        set_vec = '0;
        step();
        checks++; if (out_vld !== 1'b1)   begin errors++; $display("FAIL rh_vld got %b exp 1", out_vld); end
        checks++; if (out_idx !== 8'd4)   begin errors++; $display("FAIL rh_idx got %0d exp 4", out_idx); end
        checks++; if (Req !== W'(32'hE0)) begin errors++; $display("FAIL rh_req got %h exp e0", Req); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rh_rst_vld got %b exp 0", out_vld); end
        checks++; if (Req !== '0)       begin errors++; $display("FAIL rh_rst_req got %h exp 0", Req); end
        checks++; if (ptr !== 8'd0)     begin errors++; $display("FAIL rh_rst_ptr got %0d exp 0", ptr); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rh_rst_busy got %b exp 0", busy); end
        checks++; if (out_idx !== 8'd0) begin errors++; $display("FAIL rh_rst_idx got %0d exp 0", out_idx); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        set_vld     = 1'b0;
        set_vec     = '0;
        out_rdy     = 1'b0;
        force_en    = 1'b0;
        force_gnt   = '0;
        force_valid = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_rearm();
        test_err();
        test_rst_in_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_gnt_dispatch.md
# pe_gnt_dispatch

Request tracker and grant dispatcher on the far side of the 256-wide priority encoder. Holds a sticky vector of pending requests and drives it into the encoder as `Req`. Takes the one-hot `Gnt` back and converts it to a binary index. Issues the index over a valid/ready handshake, retires the granted bit, and supplies a rotating priority pointer for the programmable encoder variants.

## Interface
Parameters:
- `W`, 256, request vector width; power of two, ≥ 2
- `IW`, 8, index width, equal to log2(W)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `set_vld`  in  1  qualifies `set_vec` this cycle
- `set_vec`  in  W  new requests, ORed into the pending vector
- `Req`  out  W  pending vector, registered, drives the encoder
- `Gnt`  in  W  encoder grant, combinational from `Req`
- `valid`  in  1  encoder valid (`|Req`)
- `out_vld`  out  1  dispatched index valid
- `out_idx`  out  IW  binary index of the granted bit
- `out_rdy`  in  1  downstream accept
- `ptr`  out  IW  next priority start, `last_idx + 1` mod W
- `busy`  out  1  `|Req | out_vld`, registered-equivalent
- `err`  out  1  sticky protocol-error flag

## Operation
- Pending register P drives `Req` directly. P resets to 0.
- Output stage is a two-state FSM:
  - EMPTY: `out_vld=0`
  - HOLD: `out_vld=1`
- `cap` (capture enable) = `valid & gnt_ok & (EMPTY | out_rdy)`.
- `gnt_ok` = `Gnt` exactly one-hot and `(Gnt & ~P) == 0`.
- On `cap`:
  - `out_idx` ← encode(`Gnt`)
  - `ptr` ← encode(`Gnt`)+1, wrapping W-1 → 0
  - granted bit cleared in P
  - state → HOLD
- HOLD with `out_rdy=1` and no `cap`: state → EMPTY; `out_idx` holds its last value.
- HOLD with `out_rdy=0`: `out_vld` and `out_idx` held stable, no capture, P not cleared.
- P update each cycle:
  - P_next = (P & ~clr) | (set_vld ? set_vec : 0)
  - clr is the one-hot of the captured grant, or 0 when there is no capture.
  - The set term wins over the clear term, so a request re-armed in its own grant cycle stays pending.
- Setting an already-pending bit has no effect; requests do not count.
- `err` is set and held until `rst` in either case:
  - `valid=1` with `gnt_ok=0` (zero, multi-hot, or non-pending grant)
  - `valid` ≠ `|P`
- An erroneous cycle performs no capture and does not alter P except for the set term.
- `busy` = `|P | out_vld`.
- `ptr` changes only on `cap`.

## Timing
- Reset values:
  - `Req`=0
  - `out_vld`=0
  - `out_idx`=0
  - `ptr`=0
  - `err`=0
  - `busy`=0
- `rst` mid-operation clears P, drops any held index, and clears `err` in the same edge.
- Latency from `set_vld` at edge n:
  - bit appears on `Req` after edge n
  - captured at edge n+1 if the output stage is free
  - `out_vld` is high in cycle n+1 → n+2 window; i.e. 2 cycles from set to first dispatch.
- Throughput is one index per cycle while `out_rdy`=1 and P≠0 (capture and drain in the same edge).
- The encoder path `Req`→`Gnt`→capture is combinational within one cycle; no other combinational input-to-output paths.
- Indices leave in the encoder's priority order as evaluated on the current P. Lowest index first for the simple encoder.
- Empty boundary: with P=0 and `valid`=0, no capture; FSM drains to EMPTY on `out_rdy`.
- Wrap boundary: grant of bit W-1 gives `ptr`=0.

## Test plan
- After reset, pulse `set_vec`=0x…0A (bits 1,3), hold `out_rdy`=1 → `out_idx`=1 then 3 on consecutive cycles, first `out_vld` 2 cycles after set; `Req`=0 and `busy`=0 afterwards; `ptr` ends at 4.
- Same set with `out_rdy`=0 for 5 cycles → `out_vld`=1, `out_idx`=1 stable, `Req` keeps bit 3 only; release `out_rdy` → idx 3 next cycle.
- Set bit 255 alone → `out_idx`=255, `ptr`=0 (wrap).
- Re-set bit 5 in the same cycle it is captured → `out_idx`=5 twice in succession; bit 5 is not lost.
- Force `Gnt` to two-hot (0x3) with `valid`=1 → no capture, `err`=1 and held; P unchanged; `rst` → `err`=0.
- Assert `rst` while in HOLD with P=0xF0 → next cycle `out_vld`=0, `Req`=0, `ptr`=0, `busy`=0.
